mc_control_fsm: RTL and testbench

//  Main control FSM of the multicycle RV32I(+Zbb count) core: sequences fetch/decode/execute/memory/writeback.

---
 rtl/mc_control_fsm_if.sv | 48 ++++
 rtl/mc_control_fsm.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_fsm_if.sv
// -----------------------------------------------------------------------------
// mc_control_fsm_if
// Bundle between the multicycle control FSM and the datapath.
//   Decode inputs : opcode, funct3, funct7, rs2_fld (instruction register fields)
//   Flag inputs   : zero, less, u_less (ALU compare), mem_ready (memory handshake)
//   Control out   : pc_write, ir_write, adr_src, mem_write, reg_write, result_src,
//                   alu_src_a, alu_src_b, imm_src, alu_control, add_sub_mode
//   Status out    : illegal (sticky), state (current FSM state encoding)
// Modports: slave = the control FSM, master = the datapath side that feeds it.
// -----------------------------------------------------------------------------
interface mc_control_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs2_fld;
    logic       zero;
    logic       less;
    logic       u_less;
    logic       mem_ready;

    logic       pc_write;
    logic       ir_write;
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
    logic       add_sub_mode;
    logic       illegal;
    logic [3:0] state;

    modport slave (
        input  opcode, funct3, funct7, rs2_fld, zero, less, u_less, mem_ready,
        output pc_write, ir_write, adr_src, mem_write, reg_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, add_sub_mode,
               illegal, state
    );

    modport master (
        output opcode, funct3, funct7, rs2_fld, zero, less, u_less, mem_ready,
        input  pc_write, ir_write, adr_src, mem_write, reg_write, result_src,
               alu_src_a, alu_src_b, imm_src, alu_control, add_sub_mode,
               illegal, state
    );
endinterface

// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
// Main control FSM of the multicycle RV32I (+Zbb count) core. Sequences
// fetch / decode / execute / memory / writeback and drives the shared ALU in
// every state (PC+4, address calc, execute, branch compare).
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset (returns to FETCH, clears illegal)
//   bus  - mc_control_fsm_if.slave: IR fields, ALU flags, mem_ready in;
//          datapath mux selects, strobes, ALU op, illegal and state out
// Parameters:
//   ZBB_EN   - 1: CLZ/CTZ/CPOP decoded, 0: those encodings trap
//   MEM_WAIT - 1: memory states wait for mem_ready, 0: single-cycle memory
// -----------------------------------------------------------------------------
module mc_control_fsm #(
    parameter bit ZBB_EN   = 1'b1,
    parameter bit MEM_WAIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    mc_control_fsm_if.slave  bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_ONE  = 4'b1000;
    localparam logic [3:0] ALU_ZERO = 4'b1001;
    localparam logic [3:0] ALU_CTZ  = 4'b1010;
    localparam logic [3:0] ALU_CLZ  = 4'b1011;
    localparam logic [3:0] ALU_CPOP = 4'b1100;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_ZBB  = 7'b0110000;

    state_t     state_q;
    state_t     state_d;
    logic       illegal_q;

    logic       mem_go;
    logic       r_type;
    logic       r_bad;
    logic [3:0] exec_alu;
    logic       exec_cmp;
    logic       exec_ok;
    logic       br_take;
    logic       br_ok;

    logic       pc_write_c;
    logic       ir_write_c;
    logic       mem_write_c;
    logic       reg_write_c;
    logic       cmp_mode_c;
    logic [3:0] alu_control_c;

    // Memory access completes this cycle (always true for single-cycle memory).
    assign mem_go = !MEM_WAIT || bus.mem_ready;

    // R-type ops other than ADD/SUB/SRL/SRA only accept funct7 = 0.
    assign r_type = (state_q == S_EXECR);
    assign r_bad  = r_type && (bus.funct7 != F7_BASE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Execute-stage ALU decode, shared by EXECR and EXECI.
    always_comb begin
        exec_alu = ALU_ADD;
        exec_cmp = 1'b0;
        exec_ok  = 1'b1;
        case (bus.funct3)
            3'b000: begin
                if (r_type) begin
                    if (bus.funct7 == F7_ALT) exec_alu = ALU_SUB;
                    else if (bus.funct7 != F7_BASE) exec_ok = 1'b0;
                end
            end
            3'b111: begin exec_alu = ALU_AND; exec_ok = !r_bad; end
            3'b110: begin exec_alu = ALU_OR;  exec_ok = !r_bad; end
            3'b100: begin exec_alu = ALU_XOR; exec_ok = !r_bad; end
            3'b001: begin
                if (bus.funct7 == F7_BASE) begin
                    exec_alu = ALU_SLL;
                end else if (!r_type && ZBB_EN && (bus.funct7 == F7_ZBB)) begin
                    case (bus.rs2_fld)
                        5'b00000: exec_alu = ALU_CLZ;
                        5'b00001: exec_alu = ALU_CTZ;
                        5'b00010: exec_alu = ALU_CPOP;
                        default:  exec_ok  = 1'b0;
                    endcase
                end else begin
                    exec_ok = 1'b0;
                end
            end
            3'b101: begin
                if (bus.funct7 == F7_BASE)     exec_alu = ALU_SRL;
                else if (bus.funct7 == F7_ALT) exec_alu = ALU_SRA;
                else                           exec_ok  = 1'b0;
            end
            // SLT/SLTU: the ALU subtracts and the flag picks constant 1 or 0
            // in the same cycle, so the result lands in ALUOut directly.
            3'b010: begin
                exec_cmp = 1'b1;
                exec_alu = bus.less ? ALU_ONE : ALU_ZERO;
                exec_ok  = !r_bad;
            end
            default: begin
                exec_cmp = 1'b1;
                exec_alu = bus.u_less ? ALU_ONE : ALU_ZERO;
                exec_ok  = !r_bad;
            end
        endcase
    end

    always_comb begin
        br_take = 1'b0;
        br_ok   = 1'b1;
        case (bus.funct3)
            3'b000:  br_take = bus.zero;
            3'b001:  br_take = !bus.zero;
            3'b100:  br_take = bus.less;
            3'b101:  br_take = !bus.less;
            3'b110:  br_take = bus.u_less;
            3'b111:  br_take = !bus.u_less;
            default: br_ok   = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        pc_write_c     = 1'b0;
        ir_write_c     = 1'b0;
        mem_write_c    = 1'b0;
        reg_write_c    = 1'b0;
        cmp_mode_c     = 1'b0;
        alu_control_c  = ALU_ADD;
        bus.adr_src    = 1'b0;
        bus.result_src = 2'b00;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.imm_src    = 3'b000;
        case (state_q)
            S_FETCH: begin
                bus.alu_src_b = 2'b10;
                bus.result_src = 2'b10;
                if (mem_go) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            // Speculative branch/jump target: old PC + imm into ALUOut.
            S_DECODE: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
                bus.imm_src   = (bus.opcode == OP_JAL) ? 3'b011 : 3'b010;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                bus.imm_src   = (bus.opcode == OP_STORE) ? 3'b001 : 3'b000;
                state_d       = (bus.opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                bus.adr_src = 1'b1;
                if (mem_go) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.result_src = 2'b01;
                reg_write_c    = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.adr_src = 1'b1;
                mem_write_c = 1'b1;
                if (mem_go) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                alu_control_c = exec_alu;
                cmp_mode_c    = exec_cmp;
                state_d       = exec_ok ? S_ALUWB : S_TRAP;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            // Compare rs1 - rs2; PC is loaded from ALUOut (target from DECODE).
            S_BRANCH: begin
                bus.alu_src_a = 2'b10;
                alu_control_c = ALU_SUB;
                cmp_mode_c    = 1'b1;
                pc_write_c    = br_take && br_ok;
                state_d       = br_ok ? S_FETCH : S_TRAP;
            end
            // PC <= ALUOut (jump target) while the ALU forms old PC + 4 for rd.
            S_JAL: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                pc_write_c    = 1'b1;
                state_d       = S_ALUWB;
            end
            // rs1 + imm into ALUOut, then reuse JAL to load PC and link.
            S_JALR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                state_d       = (bus.funct3 == 3'b000) ? S_JAL : S_TRAP;
            end
            S_LUI: begin
                bus.alu_src_a = 2'b11;
                bus.alu_src_b = 2'b01;
                bus.imm_src   = 3'b100;
                state_d       = S_ALUWB;
            end
            S_AUIPC: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
                bus.imm_src   = 3'b100;
                state_d       = S_ALUWB;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    // Strobes are forced low for as long as reset is held, so a reset
    // mid-instruction cannot leave a partial write behind.
    assign bus.pc_write     = pc_write_c  && !rst;
    assign bus.ir_write     = ir_write_c  && !rst;
    assign bus.mem_write    = mem_write_c && !rst;
    assign bus.reg_write    = reg_write_c && !rst;
    assign bus.alu_control  = alu_control_c;
    assign bus.add_sub_mode = (alu_control_c == ALU_SUB) || cmp_mode_c;
    assign bus.illegal      = illegal_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic        less = 1'b0;
    logic        u_less = 1'b0;
    logic        mem_ready = 1'b1;

    int checks = 0;
    int failures = 0;

    mc_control_fsm_if bus ();
    mc_control_fsm_if bus_nz ();

    assign bus.opcode     = instr[6:0];
    assign bus.funct3     = instr[14:12];
    assign bus.funct7     = instr[31:25];
    assign bus.rs2_fld    = instr[24:20];
    assign bus.zero       = zero;
    assign bus.less       = less;
    assign bus.u_less     = u_less;
    assign bus.mem_ready  = mem_ready;

    assign bus_nz.opcode    = instr[6:0];
    assign bus_nz.funct3    = instr[14:12];
    assign bus_nz.funct7    = instr[31:25];
    assign bus_nz.rs2_fld   = instr[24:20];
    assign bus_nz.zero      = zero;
    assign bus_nz.less      = less;
    assign bus_nz.u_less    = u_less;
    assign bus_nz.mem_ready = mem_ready;

    mc_control_fsm #(.ZBB_EN(1'b1), .MEM_WAIT(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mc_control_fsm #(.ZBB_EN(1'b0), .MEM_WAIT(1'b1)) dut_nz (
        .clk (clk),
        .rst (rst),
        .bus (bus_nz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        logic        less;
        logic        u_less;
        logic [3:0]  tgt;
        logic [3:0]  alu;
        logic        asm_mode;
        logic        pcw;
        logic [3:0]  nxt;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_state(input logic [3:0] tgt, input string nm);
        int n;
        n = 0;
        while (bus.state != tgt && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (bus.state != tgt) begin
            failures++;
            $display("FAIL %s: timeout, state got %0d expected %0d", nm, bus.state, tgt);
        end
    endtask

    initial begin
        // instr, zero, less, u_less, target state, alu_control, add_sub_mode, pc_write, next state
        vecs[0]  = '{32'h00500093, 1'b0, 1'b0, 1'b0, 4'd7,  4'b0000, 1'b0, 1'b0, 4'd8};  // addi
        vecs[1]  = '{32'h402081B3, 1'b0, 1'b0, 1'b0, 4'd6,  4'b0001, 1'b1, 1'b0, 4'd8};  // sub
        vecs[2]  = '{32'h0020A1B3, 1'b0, 1'b1, 1'b0, 4'd6,  4'b1000, 1'b1, 1'b0, 4'd8};  // slt less=1
        vecs[3]  = '{32'h0020A1B3, 1'b0, 1'b0, 1'b1, 4'd6,  4'b1001, 1'b1, 1'b0, 4'd8};  // slt less=0
        vecs[4]  = '{32'h0020B1B3, 1'b0, 1'b0, 1'b1, 4'd6,  4'b1000, 1'b1, 1'b0, 4'd8};  // sltu u_less=1
        vecs[5]  = '{32'h00208063, 1'b1, 1'b0, 1'b0, 4'd9,  4'b0001, 1'b1, 1'b1, 4'd0};  // beq taken
        vecs[6]  = '{32'h00209063, 1'b1, 1'b0, 1'b0, 4'd9,  4'b0001, 1'b1, 1'b0, 4'd0};  // bne not taken
        vecs[7]  = '{32'h0020E063, 1'b0, 1'b0, 1'b1, 4'd9,  4'b0001, 1'b1, 1'b1, 4'd0};  // bltu taken
        vecs[8]  = '{32'h0020D063, 1'b0, 1'b1, 1'b0, 4'd9,  4'b0001, 1'b1, 1'b0, 4'd0};  // bge less=1
        vecs[9]  = '{32'h60009093, 1'b0, 1'b0, 1'b0, 4'd7,  4'b1011, 1'b0, 1'b0, 4'd8};  // clz
        vecs[10] = '{32'h60209093, 1'b0, 1'b0, 1'b0, 4'd7,  4'b1100, 1'b0, 1'b0, 4'd8};  // cpop
        vecs[11] = '{32'h4030D093, 1'b0, 1'b0, 1'b0, 4'd7,  4'b0111, 1'b0, 1'b0, 4'd8};  // srai
        vecs[12] = '{32'h0020F1B3, 1'b0, 1'b0, 1'b0, 4'd6,  4'b0010, 1'b0, 1'b0, 4'd8};  // and
        vecs[13] = '{32'h0040C093, 1'b0, 1'b0, 1'b0, 4'd7,  4'b0100, 1'b0, 1'b0, 4'd8};  // xori
        vecs[14] = '{32'h0020A063, 1'b1, 1'b0, 1'b0, 4'd9,  4'b0001, 1'b1, 1'b0, 4'd15}; // branch f3=010
        vecs[15] = '{32'h0000006F, 1'b0, 1'b0, 1'b0, 4'd10, 4'b0000, 1'b0, 1'b1, 4'd8};  // jal
        vecs[16] = '{32'h000000B7, 1'b0, 1'b0, 1'b0, 4'd12, 4'b0000, 1'b0, 1'b0, 4'd8};  // lui

        // Reset state while rst is held high.
        rst = 1'b1;
        mem_ready = 1'b1;
        instr = 32'h00500093;
        tick();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_pc_write", 32'(bus.pc_write), 32'd0);
        chk("rst_ir_write", 32'(bus.ir_write), 32'd0);
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_reg_write", 32'(bus.reg_write), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        chk("rst_illegal_nz", 32'(bus_nz.illegal), 32'd0);
        rst = 1'b0;

        // Table-driven decode / branch vectors.
        for (int i = 0; i < NV; i++) begin
            mem_ready = 1'b1;
            instr  = vecs[i].instr;
            zero   = vecs[i].zero;
            less   = vecs[i].less;
            u_less = vecs[i].u_less;
            do_reset();
            wait_state(vecs[i].tgt, $sformatf("vec%0d_reach", i));
            chk($sformatf("vec%0d_alu_control", i), 32'(bus.alu_control), 32'(vecs[i].alu));
            chk($sformatf("vec%0d_add_sub_mode", i), 32'(bus.add_sub_mode), 32'(vecs[i].asm_mode));
            chk($sformatf("vec%0d_pc_write", i), 32'(bus.pc_write), 32'(vecs[i].pcw));
            tick();
            chk($sformatf("vec%0d_next", i), 32'(bus.state), 32'(vecs[i].nxt));
        end
        zero = 1'b0; less = 1'b0; u_less = 1'b0;

        // addi: FETCH holds without mem_ready, then 0,1,7,8,0.
        instr = 32'h00500093;
        mem_ready = 1'b0;
        do_reset();
        tick();
        chk("fetch_hold_state", 32'(bus.state), 32'd0);
        chk("fetch_hold_ir_write", 32'(bus.ir_write), 32'd0);
        chk("fetch_hold_pc_write", 32'(bus.pc_write), 32'd0);
        mem_ready = 1'b1;
        #1;
        chk("fetch_ir_write", 32'(bus.ir_write), 32'd1);
        chk("fetch_pc_write", 32'(bus.pc_write), 32'd1);
        tick();
        chk("addi_s1", 32'(bus.state), 32'd1);
        chk("addi_s1_reg_write", 32'(bus.reg_write), 32'd0);
        tick();
        chk("addi_s7", 32'(bus.state), 32'd7);
        chk("addi_s7_reg_write", 32'(bus.reg_write), 32'd0);
        tick();
        chk("addi_s8", 32'(bus.state), 32'd8);
        chk("addi_s8_reg_write", 32'(bus.reg_write), 32'd1);
        chk("addi_s8_result_src", 32'(bus.result_src), 32'd0);
        tick();
        chk("addi_s0", 32'(bus.state), 32'd0);
        chk("addi_s0_reg_write", 32'(bus.reg_write), 32'd0);

        // lw with mem_ready low for three MEMREAD cycles.
        instr = 32'h00012083;
        mem_ready = 1'b1;
        do_reset();
        tick();
        tick();
        chk("lw_memadr", 32'(bus.state), 32'd2);
        mem_ready = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("lw_wait%0d_state", k), 32'(bus.state), 32'd3);
            chk($sformatf("lw_wait%0d_adr_src", k), 32'(bus.adr_src), 32'd1);
            tick();
        end
        mem_ready = 1'b1;
        chk("lw_ready_state", 32'(bus.state), 32'd3);
        tick();
        chk("lw_memwb", 32'(bus.state), 32'd4);
        chk("lw_memwb_result_src", 32'(bus.result_src), 32'd1);
        chk("lw_memwb_reg_write", 32'(bus.reg_write), 32'd1);
        tick();
        chk("lw_done", 32'(bus.state), 32'd0);
        chk("lw_done_reg_write", 32'(bus.reg_write), 32'd0);

        // sw held in MEMWRITE, then reset asserted mid-cycle.
        instr = 32'h0020A023;
        mem_ready = 1'b1;
        do_reset();
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        chk("sw_memwrite", 32'(bus.state), 32'd5);
        chk("sw_mem_write", 32'(bus.mem_write), 32'd1);
        tick();
        chk("sw_hold", 32'(bus.state), 32'd5);
        chk("sw_hold_mem_write", 32'(bus.mem_write), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("sw_rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("sw_rst_state", 32'(bus.state), 32'd0);
        chk("sw_rst_illegal", 32'(bus.illegal), 32'd0);
        tick();
        rst = 1'b0;
        mem_ready = 1'b1;

        // Unknown opcode traps and stays until reset.
        instr = 32'h0000007F;
        do_reset();
        tick();
        tick();
        chk("trap_state", 32'(bus.state), 32'd15);
        chk("trap_illegal", 32'(bus.illegal), 32'd1);
        chk("trap_pc_write", 32'(bus.pc_write), 32'd0);
        chk("trap_ir_write", 32'(bus.ir_write), 32'd0);
        tick();
        tick();
        tick();
        chk("trap_stay_state", 32'(bus.state), 32'd15);
        chk("trap_stay_illegal", 32'(bus.illegal), 32'd1);
        do_reset();
        chk("trap_clear_illegal", 32'(bus.illegal), 32'd0);
        chk("trap_clear_state", 32'(bus.state), 32'd0);

        // clz without Zbb traps; with Zbb it proceeds to ALUWB.
        instr = 32'h60009093;
        do_reset();
        tick();
        tick();
        tick();
        chk("nz_clz_state", 32'(bus_nz.state), 32'd15);
        chk("nz_clz_illegal", 32'(bus_nz.illegal), 32'd1);
        chk("zbb_clz_state", 32'(bus.state), 32'd8);
        chk("zbb_clz_illegal", 32'(bus.illegal), 32'd0);
        tick();
        tick();
        chk("nz_sticky_state", 32'(bus_nz.state), 32'd15);
        chk("nz_sticky_illegal", 32'(bus_nz.illegal), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
